// File: rtl/arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding, arbitration modes,
// and a wrap-around index helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Index following idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_n_rr_picker.sv
// Combinational rotating picker: first set request at or after the start index,
// wrapping around. A start index of 0 turns it into a lowest-index-first priority encoder.
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    always_comb begin
        int unsigned pos;
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (32'(start) + i) % N;
            if (!valid_c && req[IW'(pos)]) begin
                grant_c[IW'(pos)] = 1'b1;
                idx_c             = IW'(pos);
                valid_c           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-way bus arbiter with round-robin or fixed priority and a one-cycle turnaround gap.
// Optional forced revoke after MAX_HOLD owned cycles when built with ARB_TIMEOUT_EN.
module bus_arbiter_n
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         busreq,
    input  logic [NUM_REQ-1:0]         busidle,
    output logic [NUM_REQ-1:0]         busgrant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid,
    output logic                       timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ARB_MODE > ARB_FIXED || MAX_HOLD < 1) begin : g_param_check
        $error("bus_arbiter_n: illegal parameter value");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] busgrant_d;
    logic [IDX_W-1:0]   grant_id_d;
    logic               grant_valid_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [IDX_W-1:0]   start_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               release_req;
    logic               revoke_req;

    // Fixed priority is the rotating search pinned to index 0.
    assign start_idx = (ARB_MODE == ARB_FIXED) ? '0
                     : IDX_W'(wrap_inc(32'(last_owner_q), NUM_REQ));

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req     (busreq),
        .start   (start_idx),
        .grant_c (win_grant),
        .idx_c   (win_idx),
        .valid_c (win_valid)
    );

    // Owner gives up the bus only when its transaction is done and it no longer asks.
    assign release_req = busidle[grant_id] && !busreq[grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    assign revoke_req = (state_q == OWNED) && (hold_cnt_q == CNT_W'(MAX_HOLD))
                     && (|(busreq & ~busgrant));

    // Counts owned cycles including the current one, saturating at MAX_HOLD.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE:    hold_cnt_d = (|busreq) ? CNT_W'(1) : '0;
            OWNED: begin
                if (release_req || revoke_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: hold_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
            timeout    <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout    <= revoke_req;
        end
    end
`else
    assign revoke_req = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busgrant     <= '0;
            grant_id     <= '0;
            grant_valid  <= 1'b0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            busgrant     <= busgrant_d;
            grant_id     <= grant_id_d;
            grant_valid  <= grant_valid_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|busreq) state_d = OWNED;
            OWNED:   if (release_req || revoke_req) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busgrant_d    = busgrant;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        last_owner_d  = last_owner_q;
        case (state_q)
            IDLE: begin
                busgrant_d    = win_grant;
                grant_id_d    = win_valid ? win_idx : '0;
                grant_valid_d = win_valid;
            end
            OWNED: begin
                if (release_req || revoke_req) begin
                    busgrant_d    = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    last_owner_d  = grant_id;
                end
            end
            default: begin
                busgrant_d    = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: directed scenarios plus random traffic against a cycle model
// of the arbitration rules; expectations for the hold limit follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_n;

    localparam int MAXH = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] busreq, busidle;
    logic [1:0] busreq2, busidle2;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       val_a, val_b, to_a, to_b;
    logic [1:0] gnt_c;
    logic [0:0] id_c;
    logic       val_c, to_c;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner index (-1 = none), turnaround cycles left, last owner, cycles held.
    int m_owner[2];
    int m_cool[2];
    int m_last[2];
    int m_held[2];
    bit m_to[2];

    bus_arbiter_n #(.NUM_REQ(4), .ARB_MODE(arb_pkg::ARB_RR), .MAX_HOLD(MAXH)) dut_a (
        .clk(clk), .reset(reset), .busreq(busreq), .busidle(busidle),
        .busgrant(gnt_a), .grant_id(id_a), .grant_valid(val_a), .timeout(to_a));

    bus_arbiter_n #(.NUM_REQ(4), .ARB_MODE(arb_pkg::ARB_FIXED), .MAX_HOLD(MAXH)) dut_b (
        .clk(clk), .reset(reset), .busreq(busreq), .busidle(busidle),
        .busgrant(gnt_b), .grant_id(id_b), .grant_valid(val_b), .timeout(to_b));

    bus_arbiter_n dut_c (
        .clk(clk), .reset(reset), .busreq(busreq2), .busidle(busidle2),
        .busgrant(gnt_c), .grant_id(id_c), .grant_valid(val_c), .timeout(to_c));

    // m = 0: round-robin model, m = 1: fixed-priority model.
    task automatic model_edge(input int m);
        int o, w, c;
        logic [3:0] one;
        one = 4'b0001;
        if (reset) begin
            m_owner[m] = -1; m_cool[m] = 0; m_last[m] = 3; m_held[m] = 0; m_to[m] = 1'b0;
            return;
        end
        m_to[m] = 1'b0;
        if (m_owner[m] >= 0) begin
            o = m_owner[m];
            if (busidle[o] && !busreq[o]) begin
                m_last[m] = o; m_owner[m] = -1; m_cool[m] = 1;
            end else if (TO_EN && m_held[m] == MAXH && (busreq & ~(one << o)) != 4'b0) begin
                m_last[m] = o; m_owner[m] = -1; m_cool[m] = 1; m_to[m] = 1'b1;
            end else if (m_held[m] < MAXH) begin
                m_held[m]++;
            end
        end else if (m_cool[m] > 0) begin
            m_cool[m]--;
        end else if (busreq != 4'b0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                c = (m == 0) ? (m_last[m] + k) % 4 : k - 1;
                if (w < 0 && busreq[c]) w = c;
            end
            m_owner[m] = w;
            m_held[m]  = 1;
        end
    endtask

    function automatic logic [3:0] exp_grant(input int m);
        logic [3:0] one;
        one = 4'b0001;
        return (m_owner[m] >= 0) ? (one << m_owner[m]) : 4'b0000;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; busreq = 4'hF; busidle = 4'h0; busreq2 = 2'b11; busidle2 = 2'b00;
        step();
        step();
        n_vec++; if (gnt_a !== 4'b0 || val_a !== 1'b0 || id_a !== 2'd0 || to_a !== 1'b0) begin
            n_err++; $display("FAIL reset_a got grant=%b valid=%b id=%0d to=%b want 0000/0/0/0", gnt_a, val_a, id_a, to_a);
        end
        n_vec++; if (gnt_b !== 4'b0 || val_b !== 1'b0 || id_b !== 2'd0 || to_b !== 1'b0) begin
            n_err++; $display("FAIL reset_b got grant=%b valid=%b id=%0d to=%b want 0000/0/0/0", gnt_b, val_b, id_b, to_b);
        end
        n_vec++; if (gnt_c !== 2'b0 || val_c !== 1'b0 || id_c !== 1'b0 || to_c !== 1'b0) begin
            n_err++; $display("FAIL reset_c got grant=%b valid=%b id=%0d to=%b want 00/0/0/0", gnt_c, val_c, id_c, to_c);
        end
        busreq = 4'h0; busreq2 = 2'b00;
    endtask

    task automatic test_rr_two();
        reset = 1'b1; step(); reset = 1'b0;
        busreq2 = 2'b11; busidle2 = 2'b00;
        step();
        n_vec++; if (gnt_c !== 2'b01 || id_c !== 1'b0 || val_c !== 1'b1) begin
            n_err++; $display("FAIL rr2_first got grant=%b id=%0d valid=%b want 01/0/1", gnt_c, id_c, val_c);
        end
        step();
        n_vec++; if (gnt_c !== 2'b01) begin
            n_err++; $display("FAIL rr2_hold got %b want 01", gnt_c);
        end
        busreq2 = 2'b10; busidle2 = 2'b01;
        step();
        n_vec++; if (gnt_c !== 2'b00 || val_c !== 1'b0) begin
            n_err++; $display("FAIL rr2_release got grant=%b valid=%b want 00/0", gnt_c, val_c);
        end
        busreq2 = 2'b11; busidle2 = 2'b00;
        step();
        n_vec++; if (gnt_c !== 2'b00) begin
            n_err++; $display("FAIL rr2_turn got %b want 00", gnt_c);
        end
        step();
        n_vec++; if (gnt_c !== 2'b10 || id_c !== 1'b1 || val_c !== 1'b1) begin
            n_err++; $display("FAIL rr2_second got grant=%b id=%0d valid=%b want 10/1/1", gnt_c, id_c, val_c);
        end
        busreq2 = 2'b00; busidle2 = 2'b00;
    endtask

    task automatic test_fixed_priority();
        reset = 1'b1; busreq = 4'h0; busidle = 4'h0; step(); reset = 1'b0;
        busreq = 4'b1100;
        step();
        n_vec++; if (gnt_b !== 4'b0100 || id_b !== 2'd2) begin
            n_err++; $display("FAIL fixed_first got grant=%b id=%0d want 0100/2", gnt_b, id_b);
        end
        for (int r = 0; r < 5; r++) begin
            for (int h = 0; h < 3; h++) begin
                step();
                n_vec++; if (gnt_b !== 4'b0100) begin
                    n_err++; $display("FAIL fixed_hold r=%0d got %b want 0100", r, gnt_b);
                end
            end
            busreq = 4'b1000; busidle = 4'b0100;
            step();
            n_vec++; if (gnt_b !== 4'b0000) begin
                n_err++; $display("FAIL fixed_release r=%0d got %b want 0000", r, gnt_b);
            end
            busreq = 4'b1100; busidle = 4'b0000;
            step();
            n_vec++; if (gnt_b !== 4'b0000) begin
                n_err++; $display("FAIL fixed_turn r=%0d got %b want 0000", r, gnt_b);
            end
            step();
            n_vec++; if (gnt_b !== 4'b0100 || id_b !== 2'd2) begin
                n_err++; $display("FAIL fixed_regrant r=%0d got grant=%b id=%0d want 0100/2", r, gnt_b, id_b);
            end
        end
        busreq = 4'h0;
    endtask

    task automatic test_hold_limit();
        logic [3:0] eg;
        logic       et;
        reset = 1'b1; busreq = 4'h0; busidle = 4'h0; step(); reset = 1'b0;
        busreq = 4'b0001;
        step();
        n_vec++; if (gnt_a !== 4'b0001) begin
            n_err++; $display("FAIL hold_start got %b want 0001", gnt_a);
        end
        busreq = 4'b0011;
        for (int k = 1; k <= 100; k++) begin
            step();
`ifdef ARB_TIMEOUT_EN
            if (k <= 10) begin
                eg = (k < 8) ? 4'b0001 : ((k == 10) ? 4'b0010 : 4'b0000);
                et = (k == 8);
            end else begin
                eg = exp_grant(0);
                et = m_to[0];
            end
`else
            eg = 4'b0001;
            et = 1'b0;
`endif
            n_vec++; if (gnt_a !== eg) begin
                n_err++; $display("FAIL hold_grant k=%0d got %b want %b", k, gnt_a, eg);
            end
            n_vec++; if (to_a !== et) begin
                n_err++; $display("FAIL hold_timeout k=%0d got %b want %b", k, to_a, et);
            end
        end
        busreq = 4'h0;
    endtask

    task automatic test_mid_reset();
        reset = 1'b1; busreq = 4'h0; busidle = 4'h0; step(); reset = 1'b0;
        busreq = 4'b1111;
        for (int c = 1; c <= 4; c++) step();
        n_vec++; if (gnt_a !== 4'b0001) begin
            n_err++; $display("FAIL midrst_pre got %b want 0001", gnt_a);
        end
        reset = 1'b1;
        step();
        n_vec++; if (gnt_a !== 4'b0 || val_a !== 1'b0 || id_a !== 2'd0 || gnt_b !== 4'b0) begin
            n_err++; $display("FAIL midrst_clear got a=%b valid=%b id=%0d b=%b want 0000/0/0 0000", gnt_a, val_a, id_a, gnt_b);
        end
        reset = 1'b0; busreq = 4'b0011;
        step();
        n_vec++; if (gnt_a !== 4'b0001 || id_a !== 2'd0) begin
            n_err++; $display("FAIL midrst_rr_first got grant=%b id=%0d want 0001/0", gnt_a, id_a);
        end
        busreq = 4'h0;
    endtask

    task automatic test_random_traffic();
        logic [3:0] g, eg;
        logic [1:0] id;
        logic       v, t;
        reset = 1'b1; busreq = 4'h0; busidle = 4'h0; step(); reset = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset   = ($urandom_range(0, 149) == 0);
            busreq  = 4'($urandom);
            busidle = 4'($urandom) & 4'($urandom);
            step();
            for (int m = 0; m < 2; m++) begin
                g  = (m == 0) ? gnt_a : gnt_b;
                id = (m == 0) ? id_a  : id_b;
                v  = (m == 0) ? val_a : val_b;
                t  = (m == 0) ? to_a  : to_b;
                eg = exp_grant(m);
                n_vec++; if (g !== eg) begin
                    n_err++; $display("FAIL rand_grant m=%0d cyc=%0d got %b want %b", m, cyc, g, eg);
                end
                n_vec++; if (v !== (m_owner[m] >= 0)) begin
                    n_err++; $display("FAIL rand_valid m=%0d cyc=%0d got %b want %b", m, cyc, v, (m_owner[m] >= 0));
                end
                if (m_owner[m] >= 0) begin
                    n_vec++; if (32'(id) != m_owner[m]) begin
                        n_err++; $display("FAIL rand_id m=%0d cyc=%0d got %0d want %0d", m, cyc, id, m_owner[m]);
                    end
                end
                n_vec++; if (t !== m_to[m]) begin
                    n_err++; $display("FAIL rand_timeout m=%0d cyc=%0d got %b want %b", m, cyc, t, m_to[m]);
                end
                n_vec++; if ($countones(g) > 1) begin
                    n_err++; $display("FAIL rand_onehot m=%0d cyc=%0d got %b want at most one bit", m, cyc, g);
                end
            end
        end
        reset = 1'b0; busreq = 4'h0; busidle = 4'h0;
    endtask

    initial begin
        reset = 1'b1; busreq = 4'h0; busidle = 4'h0; busreq2 = 2'b00; busidle2 = 2'b00;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_cool[m] = 0; m_last[m] = 3; m_held[m] = 0; m_to[m] = 1'b0;
        end
        test_reset();
        test_rr_two();
        test_fixed_priority();
        test_hold_limit();
        test_mid_reset();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
